// File: rtl/apbif_regbank_if.sv
// APB4 bus bundle for the rotate-engine register bank.
// The master drives the request side; the slave returns data, ready and error.
interface apbif_regbank_if #(
  parameter int ADDR_W = 12
);
  logic              I_APBREG_PSEL;
  logic              I_APBREG_PENABLE;
  logic              I_APBREG_PWRITE;
  logic [ADDR_W-1:0] I_APBREG_PADDR;
  logic [31:0]       I_APBREG_PWDATA;
  logic [3:0]        I_APBREG_PSTRB;
  logic [31:0]       O_APBREG_PRDATA;
  logic              O_APBREG_PREADY;
  logic              O_APBREG_PSLVERR;

  modport master (
    output I_APBREG_PSEL, I_APBREG_PENABLE, I_APBREG_PWRITE,
           I_APBREG_PADDR, I_APBREG_PWDATA, I_APBREG_PSTRB,
    input  O_APBREG_PRDATA, O_APBREG_PREADY, O_APBREG_PSLVERR
  );

  modport slave (
    input  I_APBREG_PSEL, I_APBREG_PENABLE, I_APBREG_PWRITE,
           I_APBREG_PADDR, I_APBREG_PWDATA, I_APBREG_PSTRB,
    output O_APBREG_PRDATA, O_APBREG_PREADY, O_APBREG_PSLVERR
  );
endinterface

// File: rtl/apbif_regbank.sv
// APB4 slave register bank for the rotate engine: configuration registers,
// start/busy tracking and a maskable W1C interrupt block.
module apbif_regbank #(
  parameter int DIM_W       = 16,
  parameter int ADDR_W      = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic             I_APBREG_PCLK,
  input  logic             I_APBREG_PRESET_N,
  apbif_regbank_if.slave   apb,
  input  logic [31:0]      I_APBREG_DMA_DST_IMG,
  input  logic [DIM_W-1:0] I_APBREG_ROT_IMG_NEW_H,
  input  logic [DIM_W-1:0] I_APBREG_ROT_IMG_NEW_W,
  input  logic             I_APBREG_DONE,
  input  logic             I_APBREG_ERR,
  output logic [31:0]      O_APBREG_DMA_SRC_IMG,
  output logic [DIM_W-1:0] O_APBREG_ROT_IMG_H,
  output logic [DIM_W-1:0] O_APBREG_ROT_IMG_W,
  output logic [1:0]       O_APBREG_ROT_IMG_MODE,
  output logic             O_APBREG_ROT_IMG_DIR,
  output logic             O_APBREG_CTRL_START,
  output logic             O_APBREG_CTRL_RESET,
  output logic             O_APBREG_BUSY,
  output logic             O_APBREG_IRQ
);

  localparam logic [ADDR_W-1:0] A_SRC    = 'h00;
  localparam logic [ADDR_W-1:0] A_DST    = 'h04;
  localparam logic [ADDR_W-1:0] A_H      = 'h08;
  localparam logic [ADDR_W-1:0] A_W      = 'h0C;
  localparam logic [ADDR_W-1:0] A_NEW_H  = 'h10;
  localparam logic [ADDR_W-1:0] A_NEW_W  = 'h14;
  localparam logic [ADDR_W-1:0] A_MODE   = 'h18;
  localparam logic [ADDR_W-1:0] A_DIR    = 'h1C;
  localparam logic [ADDR_W-1:0] A_START  = 'h20;
  localparam logic [ADDR_W-1:0] A_CRST   = 'h24;
  localparam logic [ADDR_W-1:0] A_MASK   = 'h28;
  localparam logic [ADDR_W-1:0] A_STATUS = 'h2C;
  localparam logic [2:0]        WS       = 3'(WAIT_STATES);

  logic [2:0]        wait_cnt;
  logic [31:0]       src_q;
  logic [DIM_W-1:0]  h_q, w_q;
  logic [1:0]        mode_q;
  logic              dir_q;
  logic              start_q;
  logic              crst_q;
  logic              busy_q;
  logic [1:0]        mask_q;
  logic [1:0]        status_q;

  logic [ADDR_W-1:0] addr;
  logic              access, pready_c, slverr_c, wr_en, start_wr;
  logic              mapped, read_only, busy_locked;
  logic [31:0]       rd_mux;
  logic              unused_paddr_lsb;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return r;
  endfunction

  assign addr             = {apb.I_APBREG_PADDR[ADDR_W-1:2], 2'b00};
  assign unused_paddr_lsb = ^apb.I_APBREG_PADDR[1:0];
  assign access           = apb.I_APBREG_PSEL & apb.I_APBREG_PENABLE;
  // Gated by reset so an in-flight transfer is dropped the moment reset asserts.
  assign pready_c         = I_APBREG_PRESET_N & access & (wait_cnt == WS);

  always_comb begin
    mapped      = 1'b1;
    read_only   = 1'b0;
    busy_locked = 1'b0;
    rd_mux      = '0;
    case (addr)
      A_SRC:    begin rd_mux = src_q;                         busy_locked = 1'b1; end
      A_DST:    begin rd_mux = I_APBREG_DMA_DST_IMG;          read_only   = 1'b1; end
      A_H:      begin rd_mux = 32'(h_q);                      busy_locked = 1'b1; end
      A_W:      begin rd_mux = 32'(w_q);                      busy_locked = 1'b1; end
      A_NEW_H:  begin rd_mux = 32'(I_APBREG_ROT_IMG_NEW_H);   read_only   = 1'b1; end
      A_NEW_W:  begin rd_mux = 32'(I_APBREG_ROT_IMG_NEW_W);   read_only   = 1'b1; end
      A_MODE:   begin rd_mux = {30'b0, mode_q};               busy_locked = 1'b1; end
      A_DIR:    begin rd_mux = {31'b0, dir_q};                busy_locked = 1'b1; end
      A_START:  begin rd_mux = {31'b0, busy_q};               busy_locked = 1'b1; end
      A_CRST:   rd_mux = {31'b0, crst_q};
      A_MASK:   rd_mux = {30'b0, mask_q};
      A_STATUS: rd_mux = {30'b0, status_q};
      default:  mapped = 1'b0;
    endcase
  end

  assign slverr_c = ~mapped
                  | (apb.I_APBREG_PWRITE & read_only)
                  | (apb.I_APBREG_PWRITE & busy_locked & busy_q);
  assign wr_en    = pready_c & apb.I_APBREG_PWRITE & ~slverr_c;
  assign start_wr = wr_en & (addr == A_START) & apb.I_APBREG_PSTRB[0] & apb.I_APBREG_PWDATA[0];

  assign apb.O_APBREG_PREADY  = pready_c;
  assign apb.O_APBREG_PSLVERR = pready_c & slverr_c;
  assign apb.O_APBREG_PRDATA  = (pready_c & ~apb.I_APBREG_PWRITE & mapped) ? rd_mux : 32'b0;

  // Access-phase wait counter
  always_ff @(posedge I_APBREG_PCLK or negedge I_APBREG_PRESET_N) begin
    if (!I_APBREG_PRESET_N)
      wait_cnt <= '0;
    else if (!apb.I_APBREG_PSEL || pready_c)
      wait_cnt <= '0;
    else if (access && (wait_cnt < WS))
      wait_cnt <= wait_cnt + 3'd1;
  end

  // Register file, start pulse, busy and interrupt status
  always_ff @(posedge I_APBREG_PCLK or negedge I_APBREG_PRESET_N) begin
    if (!I_APBREG_PRESET_N) begin
      src_q    <= '0;
      h_q      <= '0;
      w_q      <= '0;
      mode_q   <= '0;
      dir_q    <= 1'b0;
      start_q  <= 1'b0;
      crst_q   <= 1'b0;
      busy_q   <= 1'b0;
      mask_q   <= '0;
      status_q <= '0;
    end else begin
      start_q <= start_wr;
      if (wr_en) begin
        case (addr)
          A_SRC:  src_q  <= apply_strb(src_q, apb.I_APBREG_PWDATA, apb.I_APBREG_PSTRB);
          A_H:    h_q    <= DIM_W'(apply_strb(32'(h_q), apb.I_APBREG_PWDATA, apb.I_APBREG_PSTRB));
          A_W:    w_q    <= DIM_W'(apply_strb(32'(w_q), apb.I_APBREG_PWDATA, apb.I_APBREG_PSTRB));
          A_MODE: if (apb.I_APBREG_PSTRB[0]) mode_q <= apb.I_APBREG_PWDATA[1:0];
          A_DIR:  if (apb.I_APBREG_PSTRB[0]) dir_q  <= apb.I_APBREG_PWDATA[0];
          A_CRST: if (apb.I_APBREG_PSTRB[0]) crst_q <= apb.I_APBREG_PWDATA[0];
          A_MASK: if (apb.I_APBREG_PSTRB[0]) mask_q <= apb.I_APBREG_PWDATA[1:0];
          default: ;
        endcase
      end
      // Event sets are applied after the W1C clear so a coincident event wins.
      if (wr_en && (addr == A_STATUS) && apb.I_APBREG_PSTRB[0])
        status_q <= (status_q & ~apb.I_APBREG_PWDATA[1:0]) | {I_APBREG_ERR, I_APBREG_DONE};
      else
        status_q <= status_q | {I_APBREG_ERR, I_APBREG_DONE};
      if (crst_q)
        busy_q <= 1'b0;
      else if (start_wr)
        busy_q <= 1'b1;
      else if (I_APBREG_DONE || I_APBREG_ERR)
        busy_q <= 1'b0;
    end
  end

  assign O_APBREG_DMA_SRC_IMG  = src_q;
  assign O_APBREG_ROT_IMG_H    = h_q;
  assign O_APBREG_ROT_IMG_W    = w_q;
  assign O_APBREG_ROT_IMG_MODE = mode_q;
  assign O_APBREG_ROT_IMG_DIR  = dir_q;
  assign O_APBREG_CTRL_START   = start_q;
  assign O_APBREG_CTRL_RESET   = crst_q;
  assign O_APBREG_BUSY         = busy_q;
  assign O_APBREG_IRQ          = |(status_q & mask_q);

endmodule

// File: doc/apbif_regbank.md
# apbif_regbank

Parametrised APB4 slave register bank for the rotate engine. It is the successor to the first-generation APB register interface and adds:
- configurable image-dimension width, address width and wait states;
- byte strobes and PSLVERR reporting;
- a self-clearing start pulse with busy tracking;
- a maskable, write-1-to-clear interrupt block driven by engine done/error events.

It sits between the system APB fabric and the rotate core/DMA.

## Interface
- DIM_W, 16: width of image height/width fields (1..32)
- ADDR_W, 12: number of PADDR bits decoded; upper bits ignored
- WAIT_STATES, 0: extra access-phase cycles before PREADY (0..7)
- I_APBREG_PCLK  in  1  APB clock, sole clock
- I_APBREG_PRESET_N  in  1  asynchronous active-low reset
- I_APBREG_PSEL, I_APBREG_PENABLE, I_APBREG_PWRITE  in  1  APB control
- I_APBREG_PADDR  in  ADDR_W  byte address; bits [1:0] ignored
- I_APBREG_PWDATA  in  32  write data
- I_APBREG_PSTRB  in  4  byte write strobes
- O_APBREG_PRDATA  out  32  read data; valid only while PREADY=1, otherwise 0
- O_APBREG_PREADY  out  1  transfer completion
- O_APBREG_PSLVERR  out  1  error response; valid only while PREADY=1
- I_APBREG_DMA_DST_IMG  in  32  destination address from DMA (read-only register)
- I_APBREG_ROT_IMG_NEW_H, I_APBREG_ROT_IMG_NEW_W  in  DIM_W  rotated dimensions (read-only registers)
- I_APBREG_DONE, I_APBREG_ERR  in  1  single-cycle engine event pulses
- O_APBREG_DMA_SRC_IMG  out  32  source address
- O_APBREG_ROT_IMG_H, O_APBREG_ROT_IMG_W  out  DIM_W  image dimensions
- O_APBREG_ROT_IMG_MODE  out  2  rotation mode
- O_APBREG_ROT_IMG_DIR  out  1  rotation direction
- O_APBREG_CTRL_START  out  1  one-cycle start pulse
- O_APBREG_CTRL_RESET  out  1  soft reset level to the core
- O_APBREG_BUSY  out  1  engine running
- O_APBREG_IRQ  out  1  level interrupt; equals |(INTR_STATUS & INTR_MASK)

## Operation
Register map. Unlisted bits read as 0. RW fields honour PSTRB per byte.
- 0x00 DMA_SRC_IMG, RW [31:0]
- 0x04 DMA_DST_IMG, RO
- 0x08 ROT_IMG_H, RW [DIM_W-1:0]
- 0x0C ROT_IMG_W, RW [DIM_W-1:0]
- 0x10 ROT_IMG_NEW_H, RO
- 0x14 ROT_IMG_NEW_W, RO
- 0x18 ROT_IMG_MODE, RW [1:0]
- 0x1C ROT_IMG_DIR, RW [0]
- 0x20 CTRL_START: write bit0=1 (PSTRB[0]=1) generates the start pulse and sets BUSY; reads return {31'b0, BUSY}
- 0x24 CTRL_RESET, RW [0]
- 0x28 INTR_MASK, RW [1:0]: bit0 done, bit1 err
- 0x2C INTR_STATUS, W1C [1:0]: bit0 set by DONE, bit1 set by ERR

Error responses (PSLVERR=1). In every case no register changes.
- Any unmapped address, read or write; read data is 0.
- Write to a RO register.
- Write to 0x00–0x20 while BUSY=1. CTRL_RESET, INTR_MASK and INTR_STATUS remain writable while busy.

Engine events and soft reset:
- DONE clears BUSY and sets STATUS[0].
- ERR clears BUSY and sets STATUS[1].
- CTRL_RESET=1 forces BUSY to 0; START writes are still accepted while CTRL_RESET=1.

## Timing
- Reset (async assert, sync release) clears all outputs and registers to 0, including PREADY, PSLVERR, IRQ and BUSY. Reset mid-transfer aborts the transfer with no response.
- Wait counter: 3-bit, cleared when PSEL=0 or on the completing cycle, increments each access-phase cycle (PSEL&PENABLE) while below WAIT_STATES.
- PREADY = PSEL & PENABLE & (cnt==WAIT_STATES), combinational. With WAIT_STATES=0 the access phase is 1 cycle; otherwise it is WAIT_STATES+1 cycles.
- Writes commit on the rising edge where PREADY=1.
- PRDATA and PSLVERR are combinational from current register state during the completing cycle.
- START pulse is high exactly the one cycle following the commit edge. BUSY rises on that same edge.
- Simultaneous DONE/ERR and W1C of the same bit: the set wins.
- Simultaneous DONE and START write in the same commit cycle: BUSY is judged on its pre-edge value (1), so the write gets PSLVERR and BUSY goes to 0.
- IRQ follows the registered STATUS and MASK with zero added latency.

## Test plan
- Reset then read every address: mapped registers read 0. Addr 0x30 gives PSLVERR=1, PRDATA=0.
- WAIT_STATES=3: write 0x1234 to 0x08 → PREADY on the 4th access cycle; ROT_IMG_H=0x1234 on the next cycle; readback equals 0x1234.
- Write 0xAABBCCDD to 0x00 with PSTRB=4'b0101 over prior 0 → register reads 0x00BB00DD.
- Write 1 to 0x20 → START high for exactly 1 cycle, BUSY=1. A write to 0x18 while busy → PSLVERR=1 and MODE unchanged. A DONE pulse → BUSY=0 and STATUS=0x1.
- MASK=0x3, ERR pulse → IRQ=1. Write 0x2 to 0x2C in the same cycle as a second ERR pulse → STATUS[1] stays 1. Clear again with no event → IRQ=0.
- Write to RO 0x10 → PSLVERR=1 and readback still shows I_APBREG_ROT_IMG_NEW_H. Assert reset mid-wait → PREADY=0 immediately.
